bcd_time_base: RTL



---
 rtl/bcd_time_base_pkg.sv | 27 ++
 rtl/bcd_time_base_if.sv | 33 +++
 rtl/bcd_time_base_bcd_mod_cnt.sv | 27 ++
 rtl/bcd_time_base.sv | 114 +++++++++++
 4 files changed

// File: rtl/bcd_time_base_pkg.sv
// Shared definitions for the clock time base and its consumers.
// Mode encodings, BCD field limits and the BCD successor helper.
package time_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_SET_H = 2'b01,
        MODE_SET_M = 2'b10
    } mode_e;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // Saturating >= keeps a corrupted field from ever leaving its range.
    function automatic logic [7:0] bcd_next(
        input logic [7:0] q,
        input logic [7:0] max
    );
        if (q >= max)
            return 8'h00;
        if (q[3:0] == 4'd9)
            return {q[7:4] + 4'd1, 4'd0};
        return {q[7:4], q[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_time_base_if.sv
// Time bus: button levels in, BCD time and mode out.
// master is the time base, slave is any reader/driver of it.
interface bcd_time_base_if;

    logic       KEY_MODE;
    logic       KEY_INC;
    logic [7:0] TIME_H;
    logic [7:0] TIME_M;
    logic [7:0] TIME_S;
    logic       SEC_PULSE;
    logic [1:0] MODE;

    modport master (
        input  KEY_MODE,
        input  KEY_INC,
        output TIME_H,
        output TIME_M,
        output TIME_S,
        output SEC_PULSE,
        output MODE
    );

    modport slave (
        output KEY_MODE,
        output KEY_INC,
        input  TIME_H,
        input  TIME_M,
        input  TIME_S,
        input  SEC_PULSE,
        input  MODE
    );

endinterface

// File: rtl/bcd_time_base_bcd_mod_cnt.sv
// Two-digit BCD modulo counter, wraps MAX -> 00.
// carry flags the increment that wraps the field.
module bcd_mod_cnt
    import time_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] q,
    output logic       carry
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= 8'h00;
        else if (clr)
            q <= 8'h00;
        else if (inc)
            q <= bcd_next(q, MAX);
    end

    assign carry = inc & (q == MAX);

endmodule

// File: rtl/bcd_time_base.sv
// Clock time base: 1 Hz prescaler, HH:MM:SS BCD chain and set-mode FSM.
// Button rises are edge-detected here; mode change beats INC and tick.
module bcd_time_base
    import time_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic CP,
    input  logic nCR,
    bcd_time_base_if.master bus
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    mode_e            state;
    logic [CNT_W-1:0] presc;
    logic             mode_prev;
    logic             inc_prev;
    logic             armed;
    logic             sec_pulse;

    logic             mode_rise;
    logic             inc_rise;
    logic             run;
    logic             tick;
    logic             enter_set;
    logic             m_inc;
    logic             h_inc;
    logic             s_carry;
    logic             m_carry;
    logic             h_carry_unused;
    logic [7:0]       time_h;
    logic [7:0]       time_m;
    logic [7:0]       time_s;

    // armed masks the first cycle after reset so held keys give no event
    assign mode_rise = armed & bus.KEY_MODE & ~mode_prev;
    assign inc_rise  = armed & bus.KEY_INC & ~inc_prev & ~mode_rise;

    assign run       = (state == MODE_RUN);
    assign tick      = run & (presc == PRESC_LAST) & ~mode_rise;
    assign enter_set = run & mode_rise;

    assign m_inc = s_carry
                 | ((state == MODE_SET_M) & inc_rise);
    // minute wraps from SET_M never reach the hours
    assign h_inc = (s_carry & m_carry)
                 | ((state == MODE_SET_H) & inc_rise);

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state     <= MODE_RUN;
            presc     <= '0;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
            armed     <= 1'b0;
            sec_pulse <= 1'b0;
        end else begin
            armed     <= 1'b1;
            mode_prev <= bus.KEY_MODE;
            inc_prev  <= bus.KEY_INC;
            sec_pulse <= tick;

            if (mode_rise) begin
                unique case (state)
                    MODE_RUN:   state <= MODE_SET_H;
                    MODE_SET_H: state <= MODE_SET_M;
                    MODE_SET_M: state <= MODE_RUN;
                    default:    state <= MODE_RUN;
                endcase
            end

            if (!run || mode_rise || presc == PRESC_LAST)
                presc <= '0;
            else
                presc <= presc + 1'b1;
        end
    end

    bcd_mod_cnt #(.MAX(SEC_MAX)) u_sec (
        .clk   (CP),
        .rst_n (nCR),
        .inc   (tick),
        .clr   (enter_set),
        .q     (time_s),
        .carry (s_carry)
    );

    bcd_mod_cnt #(.MAX(MIN_MAX)) u_min (
        .clk   (CP),
        .rst_n (nCR),
        .inc   (m_inc),
        .clr   (1'b0),
        .q     (time_m),
        .carry (m_carry)
    );

    bcd_mod_cnt #(.MAX(HOUR_MAX)) u_hour (
        .clk   (CP),
        .rst_n (nCR),
        .inc   (h_inc),
        .clr   (1'b0),
        .q     (time_h),
        .carry (h_carry_unused)
    );

    assign bus.TIME_H    = time_h;
    assign bus.TIME_M    = time_m;
    assign bus.TIME_S    = time_s;
    assign bus.SEC_PULSE = sec_pulse;
    assign bus.MODE      = state;

endmodule
